ternary_requant_drain: RTL and testbench
========================================

TERNARY_REQUANT_DRAIN -- requirements
Module: ternary_requant_drain

Interface
REQ-001 SHALL have parameter ACC_BITS, default 32: signed accumulator width received from the MAC array.
REQ-002 SHALL have parameter ACT_BITS, default 16: signed width of the requantized output activation.
REQ-003 SHALL have parameter SCALE_BITS, default 16: unsigned per-channel scale width.
REQ-004 SHALL have parameter NUM_CH, default 64: number of channels per drained row; CW = $clog2(NUM_CH).
REQ-005 SHALL have parameter FIFO_DEPTH, default 4: depth of the output FIFO, a power of two, at least 2.
REQ-006 SHALL have port clk, input, 1 bit: the only clock; all logic is rising-edge.
REQ-007 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-008 SHALL have port clear, input, 1 bit: synchronous flush.
REQ-009 SHALL have port acc_valid, input, 1 bit, and port acc_ready, output, 1 bit: input handshake.
REQ-010 SHALL have port acc_data, input, ACC_BITS, signed, and port acc_sat, input, 1 bit: accumulator value and its upstream saturation flag.
REQ-011 SHALL have ports scale_we, input, 1 bit; scale_addr, input, CW bits; scale_data, input, SCALE_BITS: scale table write.
REQ-012 SHALL have port shift, input, 6 bits, and port relu_en, input, 1 bit: quasi-static controls.
REQ-013 SHALL have port out_valid, output, 1 bit, and port out_ready, input, 1 bit: output handshake.
REQ-014 SHALL have port out_data, output, ACT_BITS, signed; out_ch, output, CW bits; out_last, output, 1 bit.
REQ-015 SHALL have port sat_count, output, 16 bits: count of saturation events.

Function
REQ-016 SHALL accept a beat only on a cycle where acc_valid and acc_ready are both high.
REQ-017 SHALL drive acc_ready = (fifo_count + beats in flight) < FIFO_DEPTH, from registered state only; no combinational path from out_ready.
REQ-018 SHALL run stage 1: product = acc_data * zero-extended scale[ch], full width ACC_BITS+SCALE_BITS+1, signed.
REQ-019 SHALL run stage 2 on the product: if shift>0, add 1<<(shift-1) in a width one bit wider; then arithmetic right shift by shift (round half up); shifts beyond the width yield 0 or -1.
REQ-020 SHALL, in stage 2, saturate to [-2^(ACT_BITS-1), 2^(ACT_BITS-1)-1] and push {value, ch, ch==NUM_CH-1} into the FIFO.
REQ-021 SHALL have 2-cycle latency: a beat accepted in cycle N is visible on out_valid in cycle N+2 when the FIFO is empty.
REQ-022 SHALL pop the FIFO on out_valid && out_ready; out_data, out_ch and out_last are held stable while out_valid is high and out_ready is low.
REQ-023 SHALL increment the channel counter per accepted beat and wrap it from NUM_CH-1 to 0.
REQ-024 SHALL increment sat_count by 1 for each beat with stage-2 saturation or acc_sat=1, holding at 16'hFFFF.
REQ-025 SHALL apply a scale write to beats accepted in later cycles; a beat accepted in the same cycle as a write to its address SHALL use the old value.
REQ-026 SHALL, when the FIFO is full and pops and pushes in the same cycle, keep the FIFO count unchanged and lose no data.
REQ-027 SHALL, on clear, empty the pipeline and FIFO and zero the channel counter and sat_count next cycle, leave the scale table unchanged, and drop any beat accepted in the same cycle.

Reset
REQ-028 SHALL reset asynchronously: out_valid=0, out_data=0, out_ch=0, out_last=0, sat_count=0, acc_ready=1 after release, FIFO empty, channel counter 0, all scale entries = 1.
REQ-029 SHALL, on assertion of rst_n mid-stream, discard all in-flight and buffered beats with no output handshake completing.

Configuration
REQ-030 SHALL, with macro TPU_REQUANT_RELU_EN defined and relu_en=1, clamp negative stage-2 results to 0 before saturation; with relu_en=0, pass them unchanged.
REQ-031 SHALL, without TPU_REQUANT_RELU_EN, exclude the ReLU logic and ignore relu_en.

Verification
REQ-032 SHALL cover: scale[0]=3, shift=2, acc_data=1000 -> out_data=750, out_ch=0, 2 cycles after accept.
REQ-033 SHALL cover: scale=1, shift=1, acc_data=-5 -> out_data=-2; acc_data=5 -> out_data=3.
REQ-034 SHALL cover: acc_data=32'h7FFFFFFF, scale=1, shift=0 -> out_data=32767, sat_count=1; acc_sat=1 with acc_data=0 -> sat_count=2.
REQ-035 SHALL cover: macro defined, relu_en=1, acc_data=-100 -> out_data=0; relu_en=0 -> out_data=-100.
REQ-036 SHALL cover: out_ready=0, continuous acc_valid -> exactly 4 beats accepted, then acc_ready=0; out_ready=1 -> all 4 emitted in order.
REQ-037 SHALL cover: 64 consecutive beats -> out_last=1 only on beat 64 (out_ch=63); beat 65 has out_ch=0.

Source files
------------

// File: rtl/ternary_requant_drain.sv
// Requantization drain: acc * scale[ch], rounded arithmetic shift, saturate to ACT_BITS, small output FIFO.
// Optional ReLU stage is built only when TPU_REQUANT_RELU_EN is defined.
module ternary_requant_drain #(
  parameter int ACC_BITS   = 32,
  parameter int ACT_BITS   = 16,
  parameter int SCALE_BITS = 16,
  parameter int NUM_CH     = 64,
  parameter int FIFO_DEPTH = 4,
  localparam int CW        = $clog2(NUM_CH)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         clear,
  input  logic                         acc_valid,
  output logic                         acc_ready,
  input  logic signed [ACC_BITS-1:0]   acc_data,
  input  logic                         acc_sat,
  input  logic                         scale_we,
  input  logic [CW-1:0]                scale_addr,
  input  logic [SCALE_BITS-1:0]        scale_data,
  input  logic [5:0]                   shift,
  input  logic                         relu_en,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic signed [ACT_BITS-1:0]   out_data,
  output logic [CW-1:0]                out_ch,
  output logic                         out_last,
  output logic [15:0]                  sat_count
);

  localparam int PW = ACC_BITS + SCALE_BITS + 1;
  localparam int EW = PW + 1;
  localparam int AW = $clog2(FIFO_DEPTH);

  localparam logic signed [EW-1:0] MAXV = {{(EW-ACT_BITS+1){1'b0}}, {(ACT_BITS-1){1'b1}}};
  localparam logic signed [EW-1:0] MINV = {{(EW-ACT_BITS+1){1'b1}}, {(ACT_BITS-1){1'b0}}};

  typedef struct packed {
    logic signed [ACT_BITS-1:0] data;
    logic [CW-1:0]              ch;
    logic                       last;
  } entry_t;

  logic [SCALE_BITS-1:0] scale_q [NUM_CH];
  logic [CW-1:0]         ch_q, ch_d;

  logic                  s1_valid_q;
  logic signed [PW-1:0]  s1_prod_q;
  logic [CW-1:0]         s1_ch_q;
  logic                  s1_sat_q;

  entry_t                mem_q [FIFO_DEPTH];
  logic [AW-1:0]         wr_q, rd_q;
  logic [AW:0]           cnt_q, cnt_d;
  logic [15:0]           sat_q, sat_d;

  logic                  accept, push, pop;
  logic signed [PW-1:0]  a_ext, s_ext, prod;
  logic signed [EW-1:0]  bias, rnd, shd;
  logic signed [ACT_BITS-1:0] res;
  logic                  sat2;
  entry_t                new_entry;
  logic [AW+1:0]         occupancy;

  // Ready depends only on registered occupancy, never on out_ready.
  assign occupancy = {1'b0, cnt_q} + (AW+2)'(s1_valid_q);
  assign acc_ready = occupancy < (AW+2)'(FIFO_DEPTH);
  assign accept    = acc_valid && acc_ready;

  assign out_valid = (cnt_q != '0);
  assign out_data  = mem_q[rd_q].data;
  assign out_ch    = mem_q[rd_q].ch;
  assign out_last  = mem_q[rd_q].last;
  assign sat_count = sat_q;

  assign pop  = out_valid && out_ready;
  assign push = s1_valid_q && !clear;

  assign a_ext = {{(PW-ACC_BITS){acc_data[ACC_BITS-1]}}, acc_data};
  assign s_ext = {{(PW-SCALE_BITS){1'b0}}, scale_q[ch_q]};
  assign prod  = a_ext * s_ext;

`ifndef TPU_REQUANT_RELU_EN
  logic relu_unused;
  assign relu_unused = relu_en;
`endif

  // Bias is kept only while it lands below the sign bit; larger shifts leave pure sign fill.
  always_comb begin
    bias = '0;
    if (shift != '0 && int'(shift) <= PW) bias = EW'(1) << (shift - 6'd1);
    rnd = EW'(s1_prod_q) + bias;
    shd = rnd >>> shift;
`ifdef TPU_REQUANT_RELU_EN
    if (relu_en && shd[EW-1]) shd = '0;
`endif
    sat2 = 1'b0;
    res  = shd[ACT_BITS-1:0];
    if (shd > MAXV) begin
      sat2 = 1'b1;
      res  = MAXV[ACT_BITS-1:0];
    end else if (shd < MINV) begin
      sat2 = 1'b1;
      res  = MINV[ACT_BITS-1:0];
    end
    new_entry.data = res;
    new_entry.ch   = s1_ch_q;
    new_entry.last = (s1_ch_q == CW'(NUM_CH-1));
  end

  always_comb begin
    ch_d = ch_q;
    if (accept) ch_d = (ch_q == CW'(NUM_CH-1)) ? '0 : ch_q + CW'(1);
    cnt_d = cnt_q;
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + (AW+1)'(1);
      2'b01:   cnt_d = cnt_q - (AW+1)'(1);
      default: cnt_d = cnt_q;
    endcase
    sat_d = sat_q;
    if (s1_valid_q && (sat2 || s1_sat_q) && sat_q != 16'hFFFF) sat_d = sat_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NUM_CH; i++) scale_q[i] <= SCALE_BITS'(1);
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      ch_q       <= '0;
      s1_valid_q <= 1'b0;
      s1_prod_q  <= '0;
      s1_ch_q    <= '0;
      s1_sat_q   <= 1'b0;
      wr_q       <= '0;
      rd_q       <= '0;
      cnt_q      <= '0;
      sat_q      <= '0;
    end else begin
      if (scale_we) scale_q[scale_addr] <= scale_data;
      if (clear) begin
        ch_q       <= '0;
        s1_valid_q <= 1'b0;
        s1_sat_q   <= 1'b0;
        wr_q       <= '0;
        rd_q       <= '0;
        cnt_q      <= '0;
        sat_q      <= '0;
      end else begin
        ch_q       <= ch_d;
        s1_valid_q <= accept;
        if (accept) begin
          s1_prod_q <= prod;
          s1_ch_q   <= ch_q;
          s1_sat_q  <= acc_sat;
        end
        if (push) begin
          mem_q[wr_q] <= new_entry;
          wr_q        <= wr_q + AW'(1);
        end
        if (pop) rd_q <= rd_q + AW'(1);
        cnt_q <= cnt_d;
        sat_q <= sat_d;
      end
    end
  end

endmodule

// File: tb/tb_ternary_requant_drain.sv
// Directed bench for ternary_requant_drain: vector table plus hand-written backpressure, clear and reset sequences.
module tb_ternary_requant_drain;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               clear = 1'b0;
  logic               acc_valid = 1'b0;
  logic               acc_ready;
  logic signed [31:0] acc_data = '0;
  logic               acc_sat = 1'b0;
  logic               scale_we = 1'b0;
  logic [5:0]         scale_addr = '0;
  logic [15:0]        scale_data = '0;
  logic [5:0]         shift = '0;
  logic               relu_en = 1'b0;
  logic               out_valid;
  logic               out_ready = 1'b1;
  logic signed [15:0] out_data;
  logic [5:0]         out_ch;
  logic               out_last;
  logic [15:0]        sat_count;

  int checks = 0;
  int failures = 0;

  ternary_requant_drain #(
    .ACC_BITS(32), .ACT_BITS(16), .SCALE_BITS(16), .NUM_CH(64), .FIFO_DEPTH(4)
  ) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear),
    .acc_valid(acc_valid), .acc_ready(acc_ready),
    .acc_data(acc_data), .acc_sat(acc_sat),
    .scale_we(scale_we), .scale_addr(scale_addr), .scale_data(scale_data),
    .shift(shift), .relu_en(relu_en),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_ch(out_ch), .out_last(out_last),
    .sat_count(sat_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    int data;
    int ch;
    int last;
  } obs_t;
  obs_t q[$];

  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready)
      q.push_back('{int'(out_data), int'(out_ch), int'(out_last)});
  end

  typedef struct {
    logic [15:0]        scale;
    logic [5:0]         shft;
    logic signed [31:0] acc;
    logic               sat;
    int                 expv;
    int                 inc;
  } vec_t;
  vec_t vecs[14];

  task automatic chk(input string nm, input logic signed [63:0] act, input logic signed [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_scale(input int addr, input logic [15:0] val);
    tick();
    scale_we   = 1'b1;
    scale_addr = 6'(addr);
    scale_data = val;
    tick();
    scale_we   = 1'b0;
  endtask

  task automatic send(input logic signed [31:0] d, input logic s, output bit ok);
    tick();
    acc_valid = 1'b1;
    acc_data  = d;
    acc_sat   = s;
    ok = 1'b0;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      if (acc_ready) ok = 1'b1;
      tick();
    end
    acc_valid = 1'b0;
    acc_sat   = 1'b0;
  endtask

  task automatic wait_out(input int n, input string nm);
    for (int i = 0; i < 300 && q.size() < n; i++) tick();
    chk(nm, q.size(), n);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit   ok;
    obs_t o;
    int   tb_ch;
    int   exp_sat;
    int   accepted;
    int   sent;

    vecs[0]  = '{16'd3,     6'd2,  32'sd1000,     1'b0,    750, 0};
    vecs[1]  = '{16'd1,     6'd1,  -32'sd5,       1'b0,     -2, 0};
    vecs[2]  = '{16'd1,     6'd1,  32'sd5,        1'b0,      3, 0};
    vecs[3]  = '{16'd1,     6'd0,  32'h7FFFFFFF,  1'b0,  32767, 1};
    vecs[4]  = '{16'd1,     6'd0,  32'sd0,        1'b1,      0, 1};
    vecs[5]  = '{16'd1,     6'd0,  -32'sd100,     1'b0,   -100, 0};
    vecs[6]  = '{16'd2,     6'd0,  -32'sd20000,   1'b0, -32768, 1};
    vecs[7]  = '{16'hFFFF,  6'd16, 32'sd1,        1'b0,      1, 0};
    vecs[8]  = '{16'd1,     6'd3,  -32'sd13,      1'b0,     -2, 0};
    vecs[9]  = '{16'd100,   6'd4,  32'sd1234,     1'b0,   7713, 0};
    vecs[10] = '{16'd1,     6'd3,  -32'sd12,      1'b0,     -1, 0};
    vecs[11] = '{16'd1,     6'd0,  -32'sd32768,   1'b0, -32768, 0};
    vecs[12] = '{16'd1,     6'd0,  32'sd32767,    1'b0,  32767, 0};
    vecs[13] = '{16'd1,     6'd0,  32'sd32768,    1'b0,  32767, 1};

    // Reset values
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_ch", out_ch, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_sat_count", sat_count, 0);
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_acc_ready", acc_ready, 1);

    // Vector table: one beat per row, channel advances each row
    tb_ch = 0;
    exp_sat = 0;
    for (int r = 0; r < 14; r++) begin
      relu_en = 1'b0;
      shift = vecs[r].shft;
      write_scale(tb_ch, vecs[r].scale);
      send(vecs[r].acc, vecs[r].sat, ok);
      chk("vec_accept", ok, 1);
      @(negedge clk);
      chk("vec_lat_n1", out_valid, 0);
      @(negedge clk);
      chk("vec_lat_n2", out_valid, 1);
      wait_out(1, "vec_out_count");
      if (q.size() > 0) begin
        o = q.pop_front();
        chk("vec_data", o.data, vecs[r].expv);
        chk("vec_ch", o.ch, tb_ch);
        chk("vec_last", o.last, 0);
      end
      exp_sat += vecs[r].inc;
      chk("vec_sat_count", sat_count, exp_sat);
      tb_ch++;
    end

    // ReLU request on a negative result
    relu_en = 1'b1;
    shift = 6'd0;
    write_scale(tb_ch, 16'd1);
    send(-32'sd100, 1'b0, ok);
    wait_out(1, "relu_out_count");
    if (q.size() > 0) begin
      o = q.pop_front();
`ifdef TPU_REQUANT_RELU_EN
      chk("relu_data", o.data, 0);
`else
      chk("relu_data", o.data, -100);
`endif
    end
    relu_en = 1'b0;
    tb_ch++;

    // Scale write in the same cycle as a beat on that channel uses the old value
    tick();
    scale_we = 1'b1;
    scale_addr = 6'(tb_ch);
    scale_data = 16'd5;
    acc_valid = 1'b1;
    acc_data = 32'sd100;
    shift = 6'd0;
    @(negedge clk);
    chk("samecyc_ready", acc_ready, 1);
    tick();
    scale_we = 1'b0;
    acc_valid = 1'b0;
    wait_out(1, "samecyc_out_count");
    if (q.size() > 0) begin
      o = q.pop_front();
      chk("samecyc_data", o.data, 100);
      chk("samecyc_ch", o.ch, tb_ch);
    end

    for (int i = 0; i < 64; i++) write_scale(i, 16'd1);

    // Clear drops a same-cycle beat and zeroes sat_count
    tick();
    clear = 1'b1;
    acc_valid = 1'b1;
    acc_data = 32'sd555;
    tick();
    clear = 1'b0;
    acc_valid = 1'b0;
    repeat (6) tick();
    @(negedge clk);
    chk("clr_drop", q.size(), 0);
    chk("clr_out_valid", out_valid, 0);
    chk("clr_sat_count", sat_count, 0);

    // Backpressure: only four beats fit
    tick();
    out_ready = 1'b0;
    acc_valid = 1'b1;
    accepted = 0;
    for (int c = 0; c < 12; c++) begin
      acc_data = 32'(10 + accepted);
      @(negedge clk);
      if (acc_ready) accepted++;
      tick();
    end
    @(negedge clk);
    chk("bp_accepted", accepted, 4);
    chk("bp_acc_ready", acc_ready, 0);
    chk("bp_out_valid", out_valid, 1);
    chk("bp_hold_data", out_data, 10);
    tick();
    @(negedge clk);
    chk("bp_hold_data2", out_data, 10);
    chk("bp_hold_ch", out_ch, 0);
    tick();
    acc_valid = 1'b0;
    out_ready = 1'b1;
    wait_out(4, "bp_out_count");
    for (int i = 0; i < 4; i++) begin
      if (q.size() > 0) begin
        o = q.pop_front();
        chk("bp_order_data", o.data, 10 + i);
        chk("bp_order_ch", o.ch, i);
      end
    end

    // 65-beat stream with intermittent out_ready: channel wrap and out_last
    tick();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    sent = 0;
    for (int c = 0; c < 600 && sent < 65; c++) begin
      acc_valid = 1'b1;
      acc_data = 32'(sent * 7 - 200);
      out_ready = (c % 3 != 2);
      @(negedge clk);
      if (acc_ready) sent++;
      tick();
    end
    acc_valid = 1'b0;
    out_ready = 1'b1;
    chk("st_sent", sent, 65);
    wait_out(65, "st_out_count");
    for (int i = 0; i < 65; i++) begin
      if (q.size() > 0) begin
        o = q.pop_front();
        chk("st_data", o.data, i * 7 - 200);
        chk("st_ch", o.ch, i % 64);
        chk("st_last", o.last, (i == 63) ? 1 : 0);
      end
    end

    // Reset mid-stream discards buffered beats and restores scale table
    write_scale(0, 16'd9);
    out_ready = 1'b0;
    shift = 6'd0;
    for (int i = 0; i < 3; i++) send(32'(40 + i), 1'b0, ok);
    @(negedge clk);
    chk("mr_pre_valid", out_valid, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mr_out_valid", out_valid, 0);
    tick();
    tick();
    rst_n = 1'b1;
    out_ready = 1'b1;
    repeat (5) tick();
    @(negedge clk);
    chk("mr_drop", q.size(), 0);
    chk("mr_acc_ready", acc_ready, 1);
    send(32'sd77, 1'b0, ok);
    wait_out(1, "mr_out_count");
    if (q.size() > 0) begin
      o = q.pop_front();
      chk("mr_scale_reset_data", o.data, 77);
      chk("mr_ch", o.ch, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
